// File: rtl/clock_domain_export.sv
// Purpose : source end of a two-phase toggle handshake; words queued in a small FIFO are
//           sent one at a time by presenting handshake_data, then inverting handshake_req.
// Latency : stb at edge E0 (idle, empty) -> handshake_data valid after E1, req toggles at E2;
//           ack change -> ack_sync match after 2 edges -> IDLE on the next edge.
// Backpressure: ready = !full; a strobe while full drops the word and pulses overflow.
//
// Ports:
//   clk, rst_n        source-domain clock, asynchronous active-low reset
//   data, stb         write word and one-cycle write strobe (accepted when ready=1)
//   ready, overflow   FIFO not full / one-cycle pulse after a dropped word
//   busy              FIFO non-empty or a transfer in progress
//   handshake_data    word presented to the other domain
//   handshake_req     toggles once per word
//   handshake_ack     peer acknowledge, asynchronous to clk (synchronized before use)
module clock_domain_export #(
   parameter int SIZE  = 8,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [SIZE-1:0] data,
   input  logic            stb,
   output logic            ready,
   output logic            overflow,
   output logic            busy,
   output logic [SIZE-1:0] handshake_data,
   output logic            handshake_req,
   input  logic            handshake_ack
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_RESYNC,
      S_IDLE,
      S_SETUP,
      S_WAIT
   } state_e;

   // ------------------------------------------------------------------
   // Acknowledge synchronizer: the only place handshake_ack is consumed.
   // ------------------------------------------------------------------
   logic ack_meta_q;
   logic ack_sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_meta_q <= 1'b0;
         ack_sync_q <= 1'b0;
      end else begin
         ack_meta_q <= handshake_ack;
         ack_sync_q <= ack_meta_q;
      end
   end

   // ------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------
   logic [SIZE-1:0] mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            overflow_q, overflow_d;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   // Fullness is judged on the current count, so a push while full is
   // dropped even when a pop frees a slot in the same cycle.
   assign push  = stb && !full;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = stb && full;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: the count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= data;
      end
   end

   // ------------------------------------------------------------------
   // Handshake state machine
   // ------------------------------------------------------------------
   state_e          state_q, state_d;
   logic [1:0]      rcnt_q, rcnt_d;
   logic            req_q, req_d;
   logic [SIZE-1:0] hs_data_q, hs_data_d;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_RESYNC;
         rcnt_q    <= 2'd0;
         req_q     <= 1'b0;
         hs_data_q <= '0;
      end else begin
         state_q   <= state_d;
         rcnt_q    <= rcnt_d;
         req_q     <= req_d;
         hs_data_q <= hs_data_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         // Two edges fill the synchronizer; the third edge samples a valid ack_sync.
         S_RESYNC: if (rcnt_q == 2'd2)        state_d = S_IDLE;
         S_IDLE:   if (!empty)                state_d = S_SETUP;
         S_SETUP:                             state_d = S_WAIT;
         S_WAIT:   if (ack_sync_q == req_q)   state_d = S_IDLE;
         default:                             state_d = S_RESYNC;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      rcnt_d    = rcnt_q;
      req_d     = req_q;
      hs_data_d = hs_data_q;
      pop       = 1'b0;
      case (state_q)
         S_RESYNC: begin
            rcnt_d = rcnt_q + 2'd1;
            if (rcnt_q == 2'd2) begin
               // Adopt the peer's phase so a one-sided reset does not look
               // like a completed (or newly started) transfer.
               req_d  = ack_sync_q;
               rcnt_d = 2'd0;
            end
         end
         S_IDLE: begin
            if (!empty) begin
               hs_data_d = mem_q[rd_ptr_q];
               pop       = 1'b1;
            end
         end
         // Data was loaded one edge earlier, so it is stable before req moves.
         S_SETUP: req_d = ~req_q;
         default: ;
      endcase
   end

   assign ready          = !full;
   assign overflow       = overflow_q;
   assign busy           = !empty || (state_q != S_IDLE);
   assign handshake_data = hs_data_q;
   assign handshake_req  = req_q;

endmodule

// File: tb/tb_clock_domain_export.sv
// Bench for clock_domain_export: a peer model answers each req toggle after a
// programmable delay and checks the received word against a scoreboard queue.
// All DUT sampling happens on the falling edge; inputs change right after it.
module tb_clock_domain_export;

   localparam int SIZE = 8;

   logic            clk;
   logic            rst_n;
   logic            stb;
   logic [SIZE-1:0] data;
   logic            ready;
   logic            overflow;
   logic            busy;
   logic [SIZE-1:0] handshake_data;
   logic            handshake_req;
   logic            handshake_ack;

   int checks = 0;
   int errors = 0;

   // Scoreboard of words the peer must receive, in order.
   logic [SIZE-1:0] sb[$];

   // Peer model state
   bit              peer_en    = 1'b0;
   logic            ack_man    = 1'b0;
   int              peer_delay = 4;
   int              wait_cnt   = 0;
   logic            last_req   = 1'b0;
   logic [SIZE-1:0] held       = '0;
   logic [SIZE-1:0] prev_data  = '0;

   clock_domain_export #(.SIZE(SIZE), .DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .data           (data),
      .stb            (stb),
      .ready          (ready),
      .overflow       (overflow),
      .busy           (busy),
      .handshake_data (handshake_data),
      .handshake_req  (handshake_req),
      .handshake_ack  (handshake_ack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got time %0t required < 400000", $time);
      $fatal(1);
   end

   // One peer step per falling edge. When disabled, ack follows ack_man.
   task automatic peer_step();
      logic [SIZE-1:0] exp;
      if (!peer_en) begin
         handshake_ack = ack_man;
         last_req      = handshake_req;
         wait_cnt      = 0;
      end else if (wait_cnt > 0) begin
         checks++;
         if (handshake_data !== held || handshake_req !== last_req) begin
            errors++;
            $display("FAIL peer_hold: data=%h req=%b, required data=%h req=%b",
                     handshake_data, handshake_req, held, last_req);
         end
         wait_cnt--;
         if (wait_cnt == 0) handshake_ack = last_req;
      end else if (handshake_req !== last_req) begin
         checks++;
         if (prev_data !== handshake_data) begin
            errors++;
            $display("FAIL peer_setup: data before toggle=%h, required %h", prev_data, handshake_data);
         end
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL peer_unexpected: got word %h, required no transfer", handshake_data);
         end else begin
            exp = sb.pop_front();
            if (handshake_data !== exp) begin
               errors++;
               $display("FAIL peer_word: got %h, required %h", handshake_data, exp);
            end
         end
         last_req = handshake_req;
         held     = handshake_data;
         wait_cnt = peer_delay;
      end
      prev_data = handshake_data;
   endtask

   task automatic cyc();
      @(negedge clk);
      peer_step();
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy !== 1'b0) && n < 300) begin
         cyc();
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL %s_drain: busy=%b pending=%0d after %0d cycles, required busy=0 pending=0",
                  name, busy, sb.size(), n);
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      stb     = 1'b0;
      data    = '0;
      peer_en = 1'b0;
      ack_man = 1'b0;
      handshake_ack = 1'b0;
      #3;
      checks++;
      if (handshake_req !== 1'b0 || handshake_data !== 8'h00 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: req=%b data=%h ovf=%b, required 0/00/0",
                  handshake_req, handshake_data, overflow);
      end
      checks++;
      if (ready !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_flags: ready=%b busy=%b, required ready=1 busy=1", ready, busy);
      end
      repeat (3) cyc();
      rst_n = 1'b1;
      repeat (4) cyc();
      checks++;
      if (busy !== 1'b0 || ready !== 1'b1 || handshake_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b ready=%b req=%b, required 0/1/0", busy, ready, handshake_req);
      end
   endtask

   task automatic test_single();
      int n;
      peer_en    = 1'b1;
      peer_delay = 6;
      cyc();
      sb.push_back(8'hA5);
      stb = 1'b1; data = 8'hA5;
      cyc();                       // after E0: word is in the FIFO
      stb = 1'b0; data = 8'h00;
      checks++;
      if (handshake_data !== 8'h00 || handshake_req !== 1'b0) begin
         errors++;
         $display("FAIL single_e0: data=%h req=%b, required 00/0", handshake_data, handshake_req);
      end
      cyc();                       // after E1: word loaded, req unchanged
      checks++;
      if (handshake_data !== 8'hA5 || handshake_req !== 1'b0) begin
         errors++;
         $display("FAIL single_e1: data=%h req=%b, required A5/0", handshake_data, handshake_req);
      end
      cyc();                       // after E2: req toggles
      checks++;
      if (handshake_data !== 8'hA5 || handshake_req !== 1'b1) begin
         errors++;
         $display("FAIL single_e2: data=%h req=%b, required A5/1", handshake_data, handshake_req);
      end
      n = 0;
      while (handshake_ack !== 1'b1 && n < 20) begin cyc(); n++; end
      checks++;
      if (handshake_ack !== 1'b1) begin
         errors++;
         $display("FAIL single_ack: ack=%b after %0d cycles, required 1", handshake_ack, n);
      end
      // Two synchronizer edges plus the WAIT->IDLE edge.
      n = 0;
      while (busy !== 1'b0 && n < 10) begin cyc(); n++; end
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL single_busy_fall: busy fell %0d edges after ack, required 3", n);
      end
   endtask

   task automatic test_burst();
      peer_delay = 10;
      sb.push_back(8'h01); sb.push_back(8'h02); sb.push_back(8'h03);
      stb = 1'b1; data = 8'h01; cyc();
      data = 8'h02; cyc();
      data = 8'h03; cyc();         // after E2: two buffered words
      checks++;
      if (ready !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL burst_full: ready=%b ovf=%b, required 0/0", ready, overflow);
      end
      data = 8'h04; cyc();         // after E3: dropped
      stb = 1'b0;
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL burst_overflow: ovf=%b, required 1", overflow);
      end
      cyc();
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL burst_overflow_pulse: ovf=%b, required 0", overflow);
      end
      wait_drain("burst");
      checks++;
      if (handshake_req !== 1'b0) begin
         errors++;
         $display("FAIL burst_req: req=%b after three toggles, required 0", handshake_req);
      end
   endtask

   task automatic test_push_pop();
      peer_delay = 3;
      sb.push_back(8'hAA); sb.push_back(8'hBB);
      stb = 1'b1; data = 8'hAA; cyc();   // one word held in IDLE
      data = 8'hBB; cyc();               // push coincides with the pop
      stb = 1'b0;
      checks++;
      if (ready !== 1'b1 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL pushpop_count: ready=%b ovf=%b, required 1/0", ready, overflow);
      end
      cyc();
      checks++;
      if (ready !== 1'b1 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL pushpop_after: ready=%b ovf=%b, required 1/0", ready, overflow);
      end
      wait_drain("pushpop");
      checks++;
      if (handshake_req !== 1'b0) begin
         errors++;
         $display("FAIL pushpop_req: req=%b, required 0", handshake_req);
      end
   endtask

   task automatic test_data_stable();
      peer_delay = 12;
      sb.push_back(8'h3C);
      stb = 1'b1; data = 8'h3C; cyc();
      stb = 1'b0; cyc(); cyc();          // now in WAIT
      checks++;
      if (handshake_data !== 8'h3C || handshake_req !== 1'b1) begin
         errors++;
         $display("FAIL stable_wait: data=%h req=%b, required 3C/1", handshake_data, handshake_req);
      end
      sb.push_back(8'h11); sb.push_back(8'h22);
      stb = 1'b1; data = 8'h11; cyc();
      data = 8'h22; cyc();
      stb = 1'b0;
      checks++;
      if (handshake_data !== 8'h3C || overflow !== 1'b0) begin
         errors++;
         $display("FAIL stable_hold: data=%h ovf=%b, required 3C/0", handshake_data, overflow);
      end
      cyc();
      checks++;
      if (handshake_data !== 8'h3C || handshake_req !== 1'b1) begin
         errors++;
         $display("FAIL stable_hold2: data=%h req=%b, required 3C/1", handshake_data, handshake_req);
      end
      wait_drain("stable");
      checks++;
      if (handshake_req !== 1'b1) begin
         errors++;
         $display("FAIL stable_req: req=%b, required 1", handshake_req);
      end
   endtask

   task automatic test_one_sided_reset();
      int   n;
      int   chg;
      logic prev;
      ack_man = handshake_ack;           // peer holds ack=1
      peer_en = 1'b0;
      cyc();
      rst_n = 1'b0;
      #1;
      checks++;
      if (handshake_req !== 1'b0) begin
         errors++;
         $display("FAIL onesided_reset: req=%b, required 0", handshake_req);
      end
      repeat (3) cyc();
      rst_n = 1'b1;
      chg  = 0;
      prev = handshake_req;
      repeat (8) begin
         cyc();
         if (handshake_req !== prev) chg++;
         prev = handshake_req;
      end
      checks++;
      if (chg != 1 || handshake_req !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL onesided_adopt: changes=%0d req=%b busy=%b, required 1/1/0", chg, handshake_req, busy);
      end
      peer_en    = 1'b1;
      peer_delay = 8;
      sb.push_back(8'h5C);
      stb = 1'b1; data = 8'h5C; cyc();
      stb = 1'b0;
      n = 0;
      while (handshake_req !== 1'b0 && n < 10) begin cyc(); n++; end
      checks++;
      if (handshake_req !== 1'b0) begin
         errors++;
         $display("FAIL onesided_toggle: req=%b, required 0", handshake_req);
      end
      repeat (4) cyc();
      checks++;
      if (busy !== 1'b1 || handshake_ack !== 1'b1) begin
         errors++;
         $display("FAIL onesided_wait: busy=%b ack=%b, required 1/1", busy, handshake_ack);
      end
      wait_drain("onesided");
      checks++;
      if (handshake_req !== 1'b0) begin
         errors++;
         $display("FAIL onesided_final: req=%b, required 0", handshake_req);
      end
   endtask

   task automatic test_reset_mid_wait();
      int   chg;
      logic prev;
      peer_delay = 20;
      sb.push_back(8'h91);
      stb = 1'b1; data = 8'h91; cyc();
      stb = 1'b0; cyc(); cyc();          // WAIT, req=1
      stb = 1'b1; data = 8'h92; cyc();   // these two are lost by the reset
      data = 8'h93; cyc();
      stb = 1'b0;
      checks++;
      if (ready !== 1'b0 || handshake_req !== 1'b1) begin
         errors++;
         $display("FAIL midwait_setup: ready=%b req=%b, required 0/1", ready, handshake_req);
      end
      ack_man = handshake_ack;
      peer_en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (handshake_req !== 1'b0 || handshake_data !== 8'h00 || overflow !== 1'b0 || ready !== 1'b1) begin
         errors++;
         $display("FAIL midwait_reset: req=%b data=%h ovf=%b ready=%b, required 0/00/0/1",
                  handshake_req, handshake_data, overflow, ready);
      end
      repeat (2) cyc();
      rst_n = 1'b1;
      chg  = 0;
      prev = handshake_req;
      repeat (8) begin
         cyc();
         if (handshake_req !== prev) chg++;
         prev = handshake_req;
      end
      checks++;
      if (chg != 0 || busy !== 1'b0 || ready !== 1'b1) begin
         errors++;
         $display("FAIL midwait_resync: changes=%0d busy=%b ready=%b, required 0/0/1", chg, busy, ready);
      end
      peer_en    = 1'b1;
      peer_delay = 4;
      sb.push_back(8'h77);
      stb = 1'b1; data = 8'h77; cyc();
      stb = 1'b0;
      wait_drain("midwait");
      checks++;
      if (handshake_req !== 1'b1) begin
         errors++;
         $display("FAIL midwait_recover: req=%b, required 1", handshake_req);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_push_pop();
      test_data_stable();
      test_one_sided_reset();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
